// File: rtl/flag_pkg.sv
// Shared types and constants for the NZVC flag update controller.
// Optional feature macro used by the controller: FLAG_FWD_EN.
package flag_pkg;

    localparam int FLAG_N_BIT = 3;
    localparam int FLAG_Z_BIT = 2;
    localparam int FLAG_V_BIT = 1;
    localparam int FLAG_C_BIT = 0;

    // Flag vector, MSB first so the packed layout matches NZVC bit numbering.
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    localparam flags_t FLAGS_CLEAR = '0;

    // Deepest chain supported; pending counter is 2 bits wide.
    localparam int FLAG_DEPTH_MAX = 3;

    // Count of valid setters across up to three stages; 3 is also the
    // saturation ceiling of the 2-bit pending counter.
    function automatic logic [1:0] pend_count(input logic [2:0] vbits);
        logic [1:0] c;
        c = 2'(vbits[0]) + 2'(vbits[1]) + 2'(vbits[2]);
        return c;
    endfunction

endpackage

// File: rtl/flag_stage_reg.sv
// One in-flight flag stage: valid bit plus NZVC payload.
// Async active-low clear, load when ld_i, otherwise hold.
module flag_stage_reg
    import flag_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   ld_i,
    input  logic   v_i,
    input  flags_t flags_i,
    output logic   v_o,
    output flags_t flags_o
);

    logic   v_q;
    flags_t flags_q;

    // Stage register: cleared by reset, advanced only when the pipeline moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= 1'b0;
            flags_q <= FLAGS_CLEAR;
        end else if (ld_i) begin
            v_q     <= v_i;
            flags_q <= flags_i;
        end
    end

    assign v_o     = v_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/flag_update_ctrl.sv
// NZVC flag scheduler: carries EX flag results down to commit, drives the
// flag register write port and resolves flags for a B.cond in ID.
// Build option: define FLAG_FWD_EN to forward in-flight flags to ID;
// otherwise ID is interlocked until the youngest setter has committed.
module flag_update_ctrl
    import flag_pkg::*;
#(
    parameter int FLAG_W     = 4,
    parameter int FLAG_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_sets_flags,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flush_ex,
    input  logic              stall_in,
    input  logic              id_valid,
    input  logic              id_uses_flags,
    input  logic [FLAG_W-1:0] arch_flags,
    output logic              set_flag,
    output logic [FLAG_W-1:0] flag_wdata,
    output logic [FLAG_W-1:0] cond_flags,
    output logic              flag_stall,
    output logic [1:0]        pending_cnt
);

    // Elaboration guard on the supported configuration range.
    if (FLAG_DEPTH < 1 || FLAG_DEPTH > FLAG_DEPTH_MAX) begin : g_bad_depth
        $error("flag_update_ctrl: FLAG_DEPTH must be 1..3");
    end
    if (FLAG_W != $bits(flags_t)) begin : g_bad_width
        $error("flag_update_ctrl: FLAG_W must match flags_t");
    end

    // A squashed EX instruction never enters the chain.
    logic ex_set;
    assign ex_set = ex_valid & ex_sets_flags & ~flush_ex;

    // Whole chain advances together; a global hold freezes every stage.
    logic ld;
    assign ld = ~stall_in;

    logic [FLAG_DEPTH-1:0] stg_v;
    flags_t                stg_f [FLAG_DEPTH];
    logic [FLAG_DEPTH-1:0] in_v;
    flags_t                in_f  [FLAG_DEPTH];

    for (genvar i = 0; i < FLAG_DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign in_v[i] = ex_set;
            assign in_f[i] = flags_t'(alu_flags);
        end else begin : g_body
            assign in_v[i] = stg_v[i-1];
            assign in_f[i] = stg_f[i-1];
        end

        flag_stage_reg u_stg (
            .clk     (clk),
            .rst_n   (reset),
            .ld_i    (ld),
            .v_i     (in_v[i]),
            .flags_i (in_f[i]),
            .v_o     (stg_v[i]),
            .flags_o (stg_f[i])
        );
    end

    // Commit from the last stage. Gating with reset makes the write drop the
    // instant reset asserts, independent of the register clear timing.
    logic commit_v;
    assign commit_v   = stg_v[FLAG_DEPTH-1];
    assign set_flag   = commit_v & ~stall_in & reset;
    assign flag_wdata = set_flag ? stg_f[FLAG_DEPTH-1] : FLAGS_CLEAR;

    // Pending counter tracks the valid bits the chain will hold after the edge.
    logic [1:0] pend_q;
    logic [1:0] pend_d;
    logic [2:0] nxt_v_pad;

    assign nxt_v_pad = 3'(in_v);
    assign pend_d    = pend_count(nxt_v_pad);

    // Registered pending count, moves in lockstep with the stage chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 2'd0;
        end else if (ld) begin
            pend_q <= pend_d;
        end
    end

    assign pending_cnt = pend_q;

`ifdef FLAG_FWD_EN
    // Forwarding: EX result first, then youngest in-flight stage, then arch.
    logic [FLAG_W-1:0] cond_sel;

    // Priority select; the loop runs oldest to youngest so the youngest wins.
    always_comb begin
        cond_sel = arch_flags;
        for (int i = FLAG_DEPTH - 1; i >= 0; i--) begin
            if (stg_v[i]) cond_sel = stg_f[i];
        end
        if (ex_set) cond_sel = alu_flags;
    end

    assign cond_flags = cond_sel;
    assign flag_stall = 1'b0;

    logic unused_id;
    assign unused_id = ^{id_valid, id_uses_flags};
`else
    // Interlock: consumer reads the architectural register and waits while
    // any setter is in EX or still in flight.
    logic any_inflight;
    assign any_inflight = |stg_v;

    assign cond_flags = arch_flags;
    assign flag_stall = reset & id_valid & id_uses_flags & (ex_set | any_inflight);
`endif

endmodule

// File: tb/tb_flag_update_ctrl.sv
// Self-checking bench for flag_update_ctrl. Reference model keeps the
// in-flight setters as a queue of {flags, stage index}; oldest at the front.
module tb_flag_update_ctrl;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ex_valid = 1'b0, ex_sets_flags = 1'b0, flush_ex = 1'b0;
    logic       stall_in = 1'b0, id_valid = 1'b0, id_uses_flags = 1'b0;
    logic [3:0] alu_flags = 4'h0;
    logic [3:0] arch_q = 4'h0;
    logic       set_flag, flag_stall;
    logic [3:0] flag_wdata, cond_flags;
    logic [1:0] pending_cnt;

    always #5 clk = ~clk;

    flag_update_ctrl #(.FLAG_W(4), .FLAG_DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_sets_flags (ex_sets_flags),
        .alu_flags     (alu_flags),
        .flush_ex      (flush_ex),
        .stall_in      (stall_in),
        .id_valid      (id_valid),
        .id_uses_flags (id_uses_flags),
        .arch_flags    (arch_q),
        .set_flag      (set_flag),
        .flag_wdata    (flag_wdata),
        .cond_flags    (cond_flags),
        .flag_stall    (flag_stall),
        .pending_cnt   (pending_cnt)
    );

    typedef struct {
        logic [3:0] f;
        int         idx;
    } ent_t;

    ent_t q[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic rst, input logic exv, input logic exs, input logic [3:0] alu,
                       input logic fl, input logic st, input logic idv, input logic idu);
        reset = rst; ex_valid = exv; ex_sets_flags = exs; alu_flags = alu;
        flush_ex = fl; stall_in = st; id_valid = idv; id_uses_flags = idu;
        if (!rst) q.delete();
    endtask

    task automatic idle(input logic st = 1'b0, input logic idv = 1'b0, input logic idu = 1'b0);
        drv(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, st, idv, idu);
    endtask

    function automatic bit m_ex_set();
        return ex_valid && ex_sets_flags && !flush_ex;
    endfunction

    function automatic bit m_commit();
        return q.size() > 0 && q[0].idx == D - 1;
    endfunction

    // Compare every output against the model, 1 time unit after drive.
    task automatic chk_all();
        logic       e_set, e_stall;
        logic [3:0] e_wd, e_cond;
        int         e_pend;
        #1;
        e_set  = m_commit() && !stall_in && reset;
        e_wd   = e_set ? q[0].f : 4'h0;
        e_pend = (q.size() > 3) ? 3 : q.size();
`ifdef FLAG_FWD_EN
        if (m_ex_set())       e_cond = alu_flags;
        else if (q.size() > 0) e_cond = q[q.size()-1].f;
        else                  e_cond = arch_q;
        e_stall = 1'b0;
`else
        e_cond  = arch_q;
        e_stall = reset && id_valid && id_uses_flags && (m_ex_set() || q.size() > 0);
`endif
        chk("set_flag",    {3'b0, set_flag},   {3'b0, e_set});
        chk("flag_wdata",  flag_wdata,         e_wd);
        chk("cond_flags",  cond_flags,         e_cond);
        chk("flag_stall",  {3'b0, flag_stall}, {3'b0, e_stall});
        chk("pending_cnt", {2'b0, pending_cnt}, 4'(e_pend));
    endtask

    // Advance model and the bench-owned flag register at the rising edge.
    task automatic tick();
        @(posedge clk);
        if (reset && !stall_in) begin
            if (m_commit()) begin
                arch_q = q[0].f;
                q.delete(0);
            end
            foreach (q[k]) q[k].idx++;
            if (m_ex_set()) q.push_back('{f: alu_flags, idx: 0});
        end
        @(negedge clk);
    endtask

    int writes;

    initial begin
        // Reset with arbitrary inputs.
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_all();
        chk("rst_set",   {3'b0, set_flag},   4'h0);
        chk("rst_stall", {3'b0, flag_stall}, 4'h0);
        chk("rst_pend",  {2'b0, pending_cnt}, 4'h0);
        chk("rst_wdata", flag_wdata, 4'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(); chk_all();
            chk("post_rst_set", {3'b0, set_flag}, 4'h0);
            tick();
        end

`ifdef FLAG_FWD_EN
        // Single setter, consumer next cycle.
        drv(1'b1, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0); chk_all(); tick();
        idle(1'b0, 1'b1, 1'b1); chk_all();
        chk("fwd1_cond", cond_flags, 4'b0100);
        chk("fwd1_stall", {3'b0, flag_stall}, 4'h0);
        chk("fwd1_pend_a", {2'b0, pending_cnt}, 4'd1);
        tick();
        idle(); chk_all();
        chk("fwd1_set", {3'b0, set_flag}, 4'h1);
        chk("fwd1_wd", flag_wdata, 4'b0100);
        chk("fwd1_pend_b", {2'b0, pending_cnt}, 4'd1);
        tick();
        idle(); chk_all();
        chk("fwd1_pend_c", {2'b0, pending_cnt}, 4'd0);
        tick();
        // Back-to-back setters, youngest wins.
        drv(1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0); chk_all(); tick();
        drv(1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0); chk_all(); tick();
        idle(1'b0, 1'b1, 1'b1); chk_all();
        chk("b2b_cond", cond_flags, 4'b0001);
        chk("b2b_wd1", flag_wdata, 4'b1000);
        tick();
        idle(); chk_all();
        chk("b2b_wd2", flag_wdata, 4'b0001);
        tick();
`else
        // Interlock: setter in EX with consumer in ID stalls 3 cycles.
        drv(1'b1, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_all(); chk("ilk_stall0", {3'b0, flag_stall}, 4'h1); tick();
        for (int k = 1; k < 3; k++) begin
            idle(1'b0, 1'b1, 1'b1); chk_all();
            chk("ilk_stall", {3'b0, flag_stall}, 4'h1); tick();
        end
        idle(1'b0, 1'b1, 1'b1); chk_all();
        chk("ilk_release", {3'b0, flag_stall}, 4'h0);
        chk("ilk_cond", cond_flags, 4'b0100);
        tick();
`endif

        // Hold with the commit stage valid: one write only after release.
        writes = 0;
        drv(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0); chk_all(); tick();
        idle(); chk_all(); tick();
        for (int k = 0; k < 2; k++) begin
            idle(1'b1); chk_all();
            chk("hold_noset", {3'b0, set_flag}, 4'h0); tick();
        end
        for (int k = 0; k < 3; k++) begin
            idle(); chk_all();
            if (set_flag === 1'b1) begin
                writes++;
                chk("hold_wd", flag_wdata, 4'b0110);
            end
            tick();
        end
        chk("hold_writes", 4'(writes), 4'd1);

        // Flushed setter never captured.
        drv(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0); chk_all(); tick();
        for (int k = 0; k < 3; k++) begin
            idle(); chk_all();
            chk("flush_noset", {3'b0, set_flag}, 4'h0);
            chk("flush_pend", {2'b0, pending_cnt}, 4'd0);
            tick();
        end

        // Async reset between edges with the commit stage valid.
        drv(1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0); chk_all(); tick();
        idle(); chk_all(); tick();
        idle(); chk_all();
        chk("ar_pre_set", {3'b0, set_flag}, 4'h1);
        #2;
        reset = 1'b0; q.delete();
        #1;
        chk("ar_set_drop", {3'b0, set_flag}, 4'h0);
        chk("ar_pend", {2'b0, pending_cnt}, 4'h0);
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            idle(); chk_all();
            chk("ar_post_set", {3'b0, set_flag}, 4'h0);
            tick();
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drv(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), ($urandom % 8 == 0),
                ($urandom % 5 == 0), 1'($urandom), 1'($urandom));
            chk_all();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_update_ctrl.md
Name: flag_update_ctrl

Overview:
- Controller and scheduler for the NZVC flag register in the 5-stage pipeline.
- Carries ALU flags produced in EX down a small in-flight pipeline (MEM, WB).
- Generates the flag register's setFlag enable and write data at commit.
- Supplies the correct flags to a flag-consuming instruction in ID (B.cond), either by forwarding or by stalling.

Parameters:
- FLAG_W, 4: flag vector width; bit3 N, bit2 Z, bit1 V, bit0 C.
- FLAG_DEPTH, 2: post-EX stages before commit, range 1..3; default 2 means commit from WB.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ex_valid  input  1  valid instruction in EX.
- ex_sets_flags  input  1  EX instruction is a flag setter (ADDS/SUBS).
- alu_flags  input  FLAG_W  ALU NZVC from EX, combinational.
- flush_ex  input  1  squash the EX instruction this cycle.
- stall_in  input  1  global pipeline hold from other hazard sources.
- id_valid  input  1  valid instruction in ID.
- id_uses_flags  input  1  ID instruction reads flags.
- arch_flags  input  FLAG_W  current flag register outputs.
- set_flag  output  1  write enable to the flag register.
- flag_wdata  output  FLAG_W  data to the flag register.
- cond_flags  output  FLAG_W  flags presented to the ID consumer.
- flag_stall  output  1  request to stall IF/ID and inject a bubble into EX.
- pending_cnt  output  2  number of uncommitted flag setters in MEM..commit.

Behaviour:
- Stage chain: stage[0..FLAG_DEPTH-1], each holding {v, flags}. stage[FLAG_DEPTH-1] is the commit stage.
- Capture, when stall_in=0 at a rising edge:
  - stage[0].v <= ex_valid & ex_sets_flags & ~flush_ex
  - stage[0].flags <= alu_flags
  - stage[i].{v,flags} <= stage[i-1]
- When stall_in=1, every stage holds unchanged. flush_ex still prevents capture of the EX instruction.
- Commit: set_flag = stage[FLAG_DEPTH-1].v & ~stall_in; flag_wdata = stage[FLAG_DEPTH-1].flags.
  - The register updates at that edge, so latency is EX to arch_flags visible in FLAG_DEPTH+1 cycles.
- Non-setters advance as v=0 bubbles. Flag values in invalid stages are don't-care, but flag_wdata is driven 0 when set_flag=0.
- pending_cnt = popcount of stage v bits, saturating at 3. It is registered, updated with the chain.
- Youngest-wins rule: when several setters are in flight, the consumer must see the youngest (the one closest to EX).
- Reset (reset=0, asynchronous): all v and flags cleared, pending_cnt=0, set_flag=0, flag_stall=0.
  - In-flight flag writes are discarded.
  - cond_flags then follows arch_flags, or the path selected by the EX-capture rule under FLAG_FWD_EN.
- Reset mid-operation: a setter in the commit stage does not write. set_flag deasserts immediately, without waiting for clk.
- Simultaneous stall_in and commit: no write; the commit repeats when stall_in drops.
- flag_stall never asserts when id_valid=0 or id_uses_flags=0.

Optional Feature:
- Macro: FLAG_FWD_EN.
- Defined (forwarding): cond_flags is selected by priority.
  - First: alu_flags, if ex_valid & ex_sets_flags & ~flush_ex.
  - Else the youngest valid stage[i], lowest i first.
  - Else arch_flags.
  - flag_stall is tied 0.
- Undefined (interlock):
  - cond_flags = arch_flags.
  - flag_stall = id_valid & id_uses_flags & (EX setter | any stage v).
  - The consumer waits until the youngest setter commits, a maximum of FLAG_DEPTH+1 stall cycles.
  - The external pipeline injects bubbles into EX while flag_stall is high.

Decomposition:
- flag_pkg holds:
  - flags_t, a packed struct {n,z,v,c} of FLAG_W bits.
  - Constants FLAG_N_BIT=3, FLAG_Z_BIT=2, FLAG_V_BIT=1, FLAG_C_BIT=0.
  - FLAGS_CLEAR = 0.
- Sub-module flag_stage_reg: one {v, flags} stage with async active-low clear, hold (stall) and load. Instantiated FLAG_DEPTH times via generate.

Test Plan:
- Reset: drive reset=0 with arbitrary inputs → set_flag=0, flag_stall=0, pending_cnt=0, flag_wdata=0. Release → no writes until a setter enters.
- Single setter, FWD, FLAG_DEPTH=2: ADDS in EX with alu_flags=4'b0100, then B.EQ in ID next cycle → cond_flags=4'b0100 from stage[0], flag_stall=0. set_flag pulses exactly 2 cycles after EX with flag_wdata=4'b0100. pending_cnt goes 1,1,0.
- Back-to-back setters, FWD: 4'b1000 then 4'b0001, consumer in ID one cycle after the second → cond_flags=4'b0001. Commits occur in order, 1000 then 0001, on consecutive cycles.
- Interlock, no macro: setter in EX with consumer in ID → flag_stall high for 3 cycles, then low. cond_flags equals the committed value 4'b0100 in the release cycle.
- Hold and flush: stall_in=1 for 2 cycles with the commit stage valid → set_flag=0 throughout, single write after release. flush_ex=1 with an EX setter → no capture, pending_cnt unchanged, no later write.
- Async reset mid-flight: assert reset=0 between edges with the commit stage valid → set_flag falls immediately. After release there is no write and pending_cnt=0.
